gen_sequencer: RTL and testbench
================================

// Module: gen_sequencer
// PURPOSE
//  Frame/generation sequencer: initiator side of the start/done handshake used by
//  renderer and life_logic. Launches one render pass per frame, and a logic pass
//  when the speed setting says a generation is due. Swaps the double buffer only
//  after a completed logic pass. Adds pause, single-step, watchdog, generation count.
// PARAMETERS
//  SPEED_W      4         width of speed_in; speed 0 = paused, max = every frame
//  GEN_W        32        width of generation counter
//  TIMEOUT_CYC  24'hFFFFFF  max cycles in WAIT before watchdog fires
// PORTS
//  clk_in            in   1        system clock (130 MHz domain)
//  rst_n_in          in   1        asynchronous active-low reset
//  speed_in          in   SPEED_W  generation rate, sampled only in LAUNCH
//  step_in           in   1        single-step pulse, honoured only while speed_in==0
//  render_done_in    in   1        1-cycle pulse: render pass finished
//  logic_done_in     in   1        1-cycle pulse: logic pass finished
//  render_start_out  out  1        1-cycle pulse: begin render pass
//  logic_start_out   out  1        1-cycle pulse: begin logic pass
//  buf_swap_out      out  1        1-cycle pulse: swap double buffer
//  gen_count_out     out  GEN_W    generations committed (swaps), wraps
//  busy_out          out  1        high in WAIT
//  timeout_out       out  1        sticky: watchdog fired since reset
// BEHAVIOUR
//  Reset (async, rst_n_in=0): all outputs 0, state=IDLE, frame_cnt=0, flags clear.
//  All outputs registered. States: IDLE -> LAUNCH -> WAIT -> (SWAP) -> LAUNCH.
//  IDLE: 1 cycle after reset release, then LAUNCH.
//  LAUNCH (1 cycle): render_start_out=1. due = step_pend | (speed!=0 &
//   frame_cnt+1 >= period), period = 2^SPEED_W - speed_in (12-bit compare, no wrap).
//   If due: logic_start_out=1 same cycle, run_logic=1, frame_cnt<=0, step_pend<=0;
//   else frame_cnt<=frame_cnt+1 (saturating). Clear r_done/l_done flags. -> WAIT.
//  WAIT: set r_done on render_done_in, l_done on logic_done_in (done pulses outside
//   WAIT are ignored). Exit when r_done & (l_done | !run_logic), evaluated on
//   flags OR current-cycle pulses: -> SWAP if run_logic, else -> LAUNCH.
//   Both dones in same cycle: both captured, exit next edge.
//  SWAP (1 cycle): buf_swap_out=1, gen_count_out+=1 (mod 2^GEN_W). -> LAUNCH.
//  Watchdog: wait_cnt counts WAIT cycles; at TIMEOUT_CYC set timeout_out (sticky),
//   -> LAUNCH without swap, gen_count unchanged, run_logic cleared.
//  step_in: when speed_in==0, sets step_pend (one pending max; extra pulses
//   dropped). step_in while speed_in!=0 ignored. Step pending + speed set later:
//   step still consumed at next LAUNCH.
//  Minimum frame: LAUNCH + 1 WAIT cycle (+ SWAP) = 2-3 cycles.
//  Reset mid-WAIT: immediate return to reset values; no swap issued.
// TESTING
//  1 speed=15, dones 10 cyc after start -> logic_start with every render_start,
//    buf_swap 1 cyc after later done, gen_count 1,2,3 over 3 frames.
//  2 speed=14 -> logic_start on every 2nd render_start; swaps only those frames.
//  3 speed=0, step_in pulse x2 before LAUNCH -> exactly one logic pass, one swap,
//    gen_count+1; subsequent frames render-only.
//  4 render_done and logic_done same cycle -> SWAP next cycle; logic_done before
//    render_done by 50 cyc -> swap waits for render_done.
//  5 TIMEOUT_CYC=100, logic_done withheld -> timeout_out=1 at WAIT cycle 100,
//    no buf_swap, next render_start follows; timeout_out stays 1.
//  6 rst_n_in low during WAIT -> all outputs 0 asynchronously; IDLE then LAUNCH.

Source files
------------

// File: rtl/gen_sequencer.sv
// -----------------------------------------------------------------------------
// gen_sequencer
//   Frame/generation sequencer. Initiator side of the start/done handshake
//   shared with the renderer and the life logic. Every frame launches a render
//   pass. A logic pass is also launched when the speed setting says a
//   generation is due, or when a single-step is pending. The double buffer is
//   swapped only after a completed logic pass. A watchdog abandons a frame that
//   waits too long.
//
//   Outputs are registered, so a pulse decided in a state becomes visible in
//   the cycle after it. For example, render_start_out is decided in LAUNCH and
//   is high during the first WAIT cycle.
//
// Ports
//   clk_in            in   1        system clock
//   rst_n_in          in   1        asynchronous active-low reset
//   speed_in          in   SPEED_W  generation rate (0 = paused, max = every frame)
//   step_in           in   1        single-step pulse, honoured while speed_in == 0
//   render_done_in    in   1        pulse: render pass finished
//   logic_done_in     in   1        pulse: logic pass finished
//   render_start_out  out  1        pulse: begin render pass
//   logic_start_out   out  1        pulse: begin logic pass
//   buf_swap_out      out  1        pulse: swap double buffer
//   gen_count_out     out  GEN_W    committed generations (swaps), wraps
//   busy_out          out  1        high while waiting for done pulses
//   timeout_out       out  1        sticky: watchdog fired since reset
// -----------------------------------------------------------------------------
module gen_sequencer #(
   parameter int unsigned SPEED_W     = 4,
   parameter int unsigned GEN_W       = 32,
   parameter logic [23:0] TIMEOUT_CYC = 24'hFFFFFF
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic [SPEED_W-1:0] speed_in,
   input  logic               step_in,
   input  logic               render_done_in,
   input  logic               logic_done_in,
   output logic               render_start_out,
   output logic               logic_start_out,
   output logic               buf_swap_out,
   output logic [GEN_W-1:0]   gen_count_out,
   output logic               busy_out,
   output logic               timeout_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_SWAP
   } state_t;

   localparam logic [11:0] FULL_SCALE = 12'(2 ** SPEED_W);

   state_t      state;
   logic [11:0] frame_cnt;
   logic        step_pend;
   logic        run_logic;
   logic        r_done;
   logic        l_done;
   logic [23:0] wait_cnt;

   logic [11:0] period;
   logic [12:0] frame_inc;
   logic        due;
   logic        r_seen;
   logic        l_seen;
   logic        wait_exit;
   logic        wd_fire;

   // period = 2^SPEED_W - speed. The compare is done one bit wider so that a
   // saturated frame_cnt of 12'hFFF does not wrap to zero and miss a generation.
   assign period    = FULL_SCALE - 12'(speed_in);
   assign frame_inc = {1'b0, frame_cnt} + 13'd1;
   assign due       = step_pend | ((speed_in != '0) & (frame_inc >= {1'b0, period}));

   // Flags OR current-cycle pulses. A done arriving on the deciding edge ends
   // the wait on that edge. It does not have to be latched first.
   assign r_seen    = r_done | render_done_in;
   assign l_seen    = l_done | logic_done_in;
   assign wait_exit = r_seen & (l_seen | ~run_logic);
   assign wd_fire   = (wait_cnt == TIMEOUT_CYC - 24'd1);

   // NOTE: all state updates use non-blocking assignments. Where two
   //       assignments hit the same register in one pass, the later one wins.
   //       The step_pend clear in LAUNCH relies on this to override the set.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state            <= S_IDLE;
         frame_cnt        <= '0;
         step_pend        <= 1'b0;
         run_logic        <= 1'b0;
         r_done           <= 1'b0;
         l_done           <= 1'b0;
         wait_cnt         <= '0;
         render_start_out <= 1'b0;
         logic_start_out  <= 1'b0;
         buf_swap_out     <= 1'b0;
         gen_count_out    <= '0;
         busy_out         <= 1'b0;
         timeout_out      <= 1'b0;
      end else begin
         render_start_out <= 1'b0;
         logic_start_out  <= 1'b0;
         buf_swap_out     <= 1'b0;

         // At most one step can be pending. Repeat pulses collapse into it.
         if (step_in && (speed_in == '0)) begin
            step_pend <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               state <= S_LAUNCH;
            end

            S_LAUNCH: begin
               render_start_out <= 1'b1;
               logic_start_out  <= due;
               run_logic        <= due;
               if (due) begin
                  frame_cnt <= '0;
                  step_pend <= 1'b0;
               end else if (frame_cnt != 12'hFFF) begin
                  frame_cnt <= frame_cnt + 12'd1;
               end
               r_done   <= 1'b0;
               l_done   <= 1'b0;
               wait_cnt <= '0;
               busy_out <= 1'b1;
               state    <= S_WAIT;
            end

            S_WAIT: begin
               if (wait_exit) begin
                  busy_out <= 1'b0;
                  if (run_logic) begin
                     buf_swap_out  <= 1'b1;
                     gen_count_out <= gen_count_out + 1'b1;
                     state         <= S_SWAP;
                  end else begin
                     state <= S_LAUNCH;
                  end
               end else if (wd_fire) begin
                  // Abandon the frame without committing a generation.
                  timeout_out <= 1'b1;
                  run_logic   <= 1'b0;
                  busy_out    <= 1'b0;
                  state       <= S_LAUNCH;
               end else begin
                  if (render_done_in) r_done <= 1'b1;
                  if (logic_done_in)  l_done <= 1'b1;
                  wait_cnt <= wait_cnt + 24'd1;
               end
            end

            S_SWAP: begin
               state <= S_LAUNCH;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gen_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gen_sequencer
//   Directed bench for gen_sequencer with a shortened watchdog.
//
//   Each frame's expected swap and generation count are pushed to a
//   scoreboard when the frame's stimulus is issued. They are popped and
//   compared when the frame ends.
// -----------------------------------------------------------------------------
module tb_gen_sequencer;

   localparam int SPEED_W = 4;
   localparam int GEN_W   = 32;

   logic               clk_in = 1'b0;
   logic               rst_n_in = 1'b0;
   logic [SPEED_W-1:0] speed_in = '0;
   logic               step_in = 1'b0;
   logic               render_done_in = 1'b0;
   logic               logic_done_in = 1'b0;
   logic               render_start_out;
   logic               logic_start_out;
   logic               buf_swap_out;
   logic [GEN_W-1:0]   gen_count_out;
   logic               busy_out;
   logic               timeout_out;

   gen_sequencer #(
      .SPEED_W     (SPEED_W),
      .GEN_W       (GEN_W),
      .TIMEOUT_CYC (24'd100)
   ) dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .speed_in         (speed_in),
      .step_in          (step_in),
      .render_done_in   (render_done_in),
      .logic_done_in    (logic_done_in),
      .render_start_out (render_start_out),
      .logic_start_out  (logic_start_out),
      .buf_swap_out     (buf_swap_out),
      .gen_count_out    (gen_count_out),
      .busy_out         (busy_out),
      .timeout_out      (timeout_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      bit          swap;
      logic [31:0] gen;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;

   // Reference model of the frame/step bookkeeping.
   int          m_cnt  = 0;
   bit          m_pend = 1'b0;
   logic [31:0] m_gen  = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Decide whether the LAUNCH just taken should have started a logic pass.
   function automatic bit model_launch();
      int period;
      bit d;
      period = (1 << SPEED_W) - int'(speed_in);
      d = m_pend || ((speed_in != 0) && (m_cnt + 1 >= period));
      if (d) begin
         m_cnt  = 0;
         m_pend = 1'b0;
      end else if (m_cnt < 4095) begin
         m_cnt++;
      end
      return d;
   endfunction

   task automatic wait_start(input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!render_start_out && n < 200);
      chk({tag, " render_start"}, 64'(render_start_out), 64'd1);
   endtask

   // One frame: responder pulses render_done rd cycles and logic_done ld
   // cycles after the start pulse. logic_done is pulsed only if a logic pass
   // is expected. 'steps' step pulses are issued on odd cycles before the dones.
   task automatic frame(input string tag, input int rd, input int ld, input int steps);
      bit   exp_l;
      exp_t e;
      int   last;
      wait_start(tag);
      exp_l = model_launch();
      chk({tag, " logic_start"}, 64'(logic_start_out), 64'(exp_l));
      chk({tag, " busy"}, 64'(busy_out), 64'd1);
      if (exp_l) m_gen++;
      e.swap = exp_l;
      e.gen  = m_gen;
      sb.push_back(e);
      last = (exp_l && ld > rd) ? ld : rd;
      for (int c = 1; c <= last; c++) begin
         render_done_in = (c == rd);
         logic_done_in  = exp_l && (c == ld);
         step_in        = (c <= 2 * steps) && (c % 2 == 1);
         if (step_in && speed_in == 0) m_pend = 1'b1;
         tick();
         if (c < last) chk({tag, " early swap"}, 64'(buf_swap_out), 64'd0);
      end
      render_done_in = 1'b0;
      logic_done_in  = 1'b0;
      step_in        = 1'b0;
      e = sb.pop_front();
      chk({tag, " buf_swap"}, 64'(buf_swap_out), 64'(e.swap));
      chk({tag, " gen_count"}, 64'(gen_count_out), 64'(e.gen));
      chk({tag, " busy end"}, 64'(busy_out), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " render_start"}, 64'(render_start_out), 64'd0);
      chk({tag, " logic_start"}, 64'(logic_start_out), 64'd0);
      chk({tag, " buf_swap"}, 64'(buf_swap_out), 64'd0);
      chk({tag, " gen_count"}, 64'(gen_count_out), 64'd0);
      chk({tag, " busy"}, 64'(busy_out), 64'd0);
      chk({tag, " timeout"}, 64'(timeout_out), 64'd0);
   endtask

   initial begin
      bit d;

      // Reset state.
      tick();
      tick();
      chk_all_zero("reset");
      rst_n_in = 1'b1;
      tick();
      chk("idle no start", 64'(render_start_out), 64'd0);

      // 1: full speed, a logic pass every frame.
      speed_in = 4'd15;
      frame("t1f1", 10, 10, 0);
      frame("t1f2", 10, 10, 0);
      frame("t1f3", 10, 10, 0);

      // 2: speed 14, a logic pass every second frame.
      speed_in = 4'd14;
      for (int i = 0; i < 4; i++) frame("t2", 6, 6, 0);

      // 3: paused, two step pulses give exactly one logic pass.
      speed_in = 4'd0;
      frame("t3 steps", 8, 8, 2);
      frame("t3 stepped", 4, 4, 0);
      frame("t3 idle a", 1, 1, 0);
      frame("t3 idle b", 3, 3, 0);

      // 4: simultaneous dones, then logic_done 50 cycles ahead of render_done.
      speed_in = 4'd15;
      frame("t4 same", 10, 10, 0);
      frame("t4 late render", 55, 5, 0);

      // 5: watchdog fires when logic_done is withheld.
      wait_start("t5");
      d = model_launch();
      chk("t5 logic_start", 64'(logic_start_out), 64'(d));
      for (int k = 1; k <= 99; k++) begin
         render_done_in = (k == 3);
         tick();
      end
      render_done_in = 1'b0;
      chk("t5 before timeout", 64'(timeout_out), 64'd0);
      chk("t5 busy before", 64'(busy_out), 64'd1);
      tick();
      chk("t5 timeout", 64'(timeout_out), 64'd1);
      chk("t5 no swap", 64'(buf_swap_out), 64'd0);
      chk("t5 busy after", 64'(busy_out), 64'd0);
      chk("t5 gen held", 64'(gen_count_out), 64'(m_gen));
      tick();
      chk("t5 next start", 64'(render_start_out), 64'd1);
      // The launch just seen falls inside the next frame's wait.
      d = model_launch();
      chk("t5 next logic_start", 64'(logic_start_out), 64'(d));
      for (int k = 1; k <= 2; k++) begin
         render_done_in = (k == 2);
         logic_done_in  = (k == 2);
         tick();
      end
      render_done_in = 1'b0;
      logic_done_in  = 1'b0;
      m_gen++;
      chk("t5 recover swap", 64'(buf_swap_out), 64'd1);
      chk("t5 recover gen", 64'(gen_count_out), 64'(m_gen));
      frame("t5 after", 3, 3, 0);
      chk("t5 sticky", 64'(timeout_out), 64'd1);

      // 6: asynchronous reset in the middle of WAIT.
      wait_start("t6");
      d = model_launch();
      tick();
      tick();
      chk("t6 busy pre", 64'(busy_out), 64'd1);
      rst_n_in = 1'b0;
      #1;
      chk_all_zero("t6 async");
      tick();
      tick();
      chk_all_zero("t6 held");
      rst_n_in = 1'b1;
      m_cnt  = 0;
      m_pend = 1'b0;
      m_gen  = '0;
      tick();
      chk("t6 idle", 64'(render_start_out), 64'd0);
      frame("t6 relaunch", 4, 4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, observed hang, expected $finish");
      $fatal(1, "global timeout");
   end

endmodule
